// File: rtl/iter_shifter_if.sv
// Request/response bundle between ALU control and the iterative shifter.
interface iter_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               ctrl_start;
    logic               ctrl_shiftop;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_operandA;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output ctrl_start, ctrl_shiftop, ctrl_shiftamt, data_operandA,
        input  data_result, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_start, ctrl_shiftop, ctrl_shiftamt, data_operandA,
        output data_result, data_resultRDY, busy
    );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one 1-bit SLL or SRA step per clock, result flagged by a one-cycle ready pulse.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic         clock,
    input  logic         reset,
    iter_shifter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic signed [WIDTH-1:0] acc;
    logic [SHAMT_W-1:0]  cnt;
    logic                op;
    logic                accept;

    function automatic logic signed [WIDTH-1:0] shift_step(
        input logic signed [WIDTH-1:0] v,
        input logic                    sra
    );
        logic signed [WIDTH-1:0] r;
        if (sra) r = v >>> 1;
        else     r = v << 1;
        return r;
    endfunction

    assign accept = bus.ctrl_start && (state != SHIFT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter is tested before decrementing, so a zero count idles one cycle instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
            op  <= 1'b0;
        end else if (accept) begin
            acc <= bus.data_operandA;
            cnt <= bus.ctrl_shiftamt;
            op  <= bus.ctrl_shiftop;
        end else if (state == SHIFT && cnt != '0) begin
            acc <= shift_step(acc, op);
            cnt <= cnt - SHAMT_W'(1);
        end
    end

    assign bus.data_result    = acc;
    assign bus.busy           = (state == SHIFT);
    assign bus.data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: expected result and ready cycle queued at start, checked on each ready pulse.
module tb_iter_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    iter_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    iter_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic op, input logic [4:0] amt, input logic [31:0] a);
        logic signed [31:0] s;
        s = a;
        if (op) return 32'(s >>> amt);
        return a << amt;
    endfunction

    // Checks every ready pulse against the oldest outstanding request.
    always @(negedge clock) begin
        if (bus.data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 32'(bus.data_resultRDY), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.data_result, e.res);
                check("rdy_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; that cycle is "cycle 0" of the request.
    task automatic issue(input logic op, input logic [4:0] amt, input logic [31:0] a);
        exp_t e;
        bus.ctrl_start    = 1'b1;
        bus.ctrl_shiftop  = op;
        bus.ctrl_shiftamt = amt;
        bus.data_operandA = a;
        e.res = model(op, amt, a);
        e.cyc = cyc + int'(amt) + 2;
        sb.push_back(e);
        step();
        bus.ctrl_start    = 1'b0;
        bus.data_operandA = $urandom;
        bus.ctrl_shiftamt = 5'($urandom);
        bus.ctrl_shiftop  = 1'($urandom);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        step();
    endtask

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.ctrl_start    = 1'b0;
        bus.ctrl_shiftop  = 1'b0;
        bus.ctrl_shiftamt = '0;
        bus.data_operandA = '0;

        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset_result", bus.data_result, 32'd0);
        step();
        reset = 1'b1;
        step();

        // SRA by 4: busy exactly in cycles 1..5, ready in cycle 6
        issue(1'b1, 5'd4, 32'h8000_0000);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            check($sformatf("busy_c%0d", i), 32'(bus.busy), (i <= 5) ? 32'd1 : 32'd0);
            @(posedge clock);
            #1;
        end
        drain(50);

        issue(1'b0, 5'd31, 32'h0000_0001);
        drain(50);
        issue(1'b0, 5'd31, 32'h0000_0003);
        drain(50);

        issue(1'b0, 5'd0, 32'hDEAD_BEEF);
        drain(10);
        issue(1'b1, 5'd0, 32'hDEAD_BEEF);
        drain(10);

        issue(1'b1, 5'd31, 32'h8000_0000);
        drain(50);
        issue(1'b1, 5'd31, 32'h4000_0000);
        drain(50);

        // starts during SHIFT must be ignored
        issue(1'b1, 5'd3, 32'h0000_0010);
        bus.ctrl_start    = 1'b1;
        bus.ctrl_shiftop  = 1'b0;
        bus.ctrl_shiftamt = 5'd7;
        bus.data_operandA = 32'hFFFF_FFFF;
        repeat (3) step();
        bus.ctrl_start = 1'b0;
        drain(20);

        // second start lands in the first op's ready cycle
        issue(1'b0, 5'd2, 32'h0000_0005);
        repeat (3) step();
        check("b2b_rdy_present", 32'(bus.data_resultRDY), 32'd1);
        issue(1'b1, 5'd8, 32'hFFFF_FF00);
        drain(30);

        // async reset in cycle 3 of a 20-step shift
        issue(1'b0, 5'd20, 32'h0000_0001);
        repeat (2) step();
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.data_result, 32'd0);
        check("abort_rdy", 32'(bus.data_resultRDY), 32'd0);
        sb.delete();
        step();
        reset = 1'b1;
        repeat (25) step();
        issue(1'b1, 5'd5, 32'h8123_4567);
        drain(20);

        for (int i = 0; i < 6; i++) begin
            issue(1'($urandom), 5'($urandom), $urandom);
            drain(50);
        end

        check("final_pending", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
